// File: rtl/game_pkg.sv
// Shared game-flow definitions: state encoding seen by the frog module and
// the controller, plus playfield geometry.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PLAY    = 2'b01,
        ST_RESPAWN = 2'b10,
        ST_OVER    = 2'b11
    } game_state_t;

    localparam int BLOCKSIZE = 32;
    localparam int START_ROW = 14;

endpackage

// File: rtl/frame_timer.sv
// Frame counter with clear, tick enable and saturation at a runtime limit.
// done is high while the count sits exactly at the limit.
module frame_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Clear wins over a coincident tick so a freshly entered state starts at zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick && (count < limit)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == limit);

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: IDLE/PLAY/RESPAWN/OVER sequencing, lives, goals,
// score and event pulses. Optional GAME_CTRL_HISCORE_EN adds a hiscore output.
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT     = 3,
    parameter int GOALS_TO_WIN   = 5,
    parameter int RESPAWN_FRAMES = 30,
    parameter int OVER_FRAMES    = 120,
    parameter int ROW_SHIFT      = $clog2(BLOCKSIZE),
    parameter int START_ROW      = game_pkg::START_ROW,
    parameter int WIN_BONUS      = 50,
    parameter int SCORE_W        = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [3:0]         dpad_input,
    input  logic               collision,
    input  logic               reached_end,
    input  logic [9:0]         frog_y,
    output logic [1:0]         state,
    output logic [2:0]         lives,
    output logic [2:0]         goals,
    output logic [SCORE_W-1:0] score,
    output logic               game_won,
    output logic               death_pulse,
    output logic               win_pulse,
    output logic               lose_pulse
`ifdef GAME_CTRL_HISCORE_EN
    ,
    output logic [SCORE_W-1:0] hiscore
`endif
);

    localparam int ROW_W   = 10 - ROW_SHIFT;
    localparam int CNT_MAX = (OVER_FRAMES > RESPAWN_FRAMES) ? OVER_FRAMES : RESPAWN_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    game_state_t        state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic [2:0]         goals_q, goals_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               game_won_q, game_won_d;
    logic [ROW_W-1:0]   best_row_q, best_row_d;
    logic               death_d, win_d, lose_d;
    logic [3:0]         dpad_prev;

    logic               press;
    logic [ROW_W-1:0]   row;
    logic [SCORE_W:0]   score_plus_bonus, score_plus_one;
    logic [SCORE_W-1:0] score_bonus_sat, score_one_sat;

    logic               timer_clear, timer_tick, timer_done;
    logic [CNT_W-1:0]   timer_limit;

    assign press = |(dpad_input & ~dpad_prev);
    assign row   = ROW_W'(frog_y >> ROW_SHIFT);

    // One extra bit catches overflow so the score clamps instead of wrapping.
    assign score_plus_bonus = {1'b0, score_q} + (SCORE_W+1)'(WIN_BONUS);
    assign score_plus_one   = {1'b0, score_q} + 1'b1;
    assign score_bonus_sat  = score_plus_bonus[SCORE_W] ? SCORE_MAX : score_plus_bonus[SCORE_W-1:0];
    assign score_one_sat    = score_plus_one[SCORE_W]   ? SCORE_MAX : score_plus_one[SCORE_W-1:0];

    assign timer_limit = (state_q == ST_OVER) ? CNT_W'(OVER_FRAMES) : CNT_W'(RESPAWN_FRAMES - 1);

    frame_timer #(
        .CNT_W (CNT_W)
    ) u_frame_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .tick  (timer_tick),
        .limit (timer_limit),
        .done  (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lives_q     <= 3'(LIVES_INIT);
            goals_q     <= '0;
            score_q     <= '0;
            game_won_q  <= 1'b0;
            best_row_q  <= ROW_W'(START_ROW);
            death_pulse <= 1'b0;
            win_pulse   <= 1'b0;
            lose_pulse  <= 1'b0;
            dpad_prev   <= '0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            goals_q     <= goals_d;
            score_q     <= score_d;
            game_won_q  <= game_won_d;
            best_row_q  <= best_row_d;
            death_pulse <= death_d;
            win_pulse   <= win_d;
            lose_pulse  <= lose_d;
            dpad_prev   <= dpad_input;
        end
    end

    // PLAY priority: collision beats reached_end beats forward-row credit.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        goals_d     = goals_q;
        score_d     = score_q;
        game_won_d  = game_won_q;
        best_row_d  = best_row_q;
        death_d     = 1'b0;
        win_d       = 1'b0;
        lose_d      = 1'b0;
        timer_clear = 1'b0;
        timer_tick  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d     = ST_PLAY;
                    lives_d     = 3'(LIVES_INIT);
                    goals_d     = '0;
                    score_d     = '0;
                    game_won_d  = 1'b0;
                    best_row_d  = ROW_W'(START_ROW);
                    timer_clear = 1'b1;
                end
            end
            ST_PLAY: begin
                if (collision) begin
                    lives_d     = lives_q - 3'd1;
                    death_d     = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = ST_RESPAWN;
                end else if (reached_end) begin
                    goals_d     = goals_q + 3'd1;
                    score_d     = score_bonus_sat;
                    timer_clear = 1'b1;
                    if ((int'(goals_q) + 1) == GOALS_TO_WIN) begin
                        game_won_d = 1'b1;
                        win_d      = 1'b1;
                        state_d    = ST_OVER;
                    end else begin
                        state_d    = ST_RESPAWN;
                    end
                end else if (row < best_row_q) begin
                    score_d    = score_one_sat;
                    best_row_d = row;
                end
            end
            ST_RESPAWN: begin
                timer_tick = frame_tick;
                if (frame_tick && timer_done) begin
                    best_row_d  = ROW_W'(START_ROW);
                    timer_clear = 1'b1;
                    if (lives_q == 3'd0) begin
                        game_won_d = 1'b0;
                        lose_d     = 1'b1;
                        state_d    = ST_OVER;
                    end else begin
                        state_d    = ST_PLAY;
                    end
                end
            end
            ST_OVER: begin
                timer_tick = frame_tick;
                if (timer_done && press) begin
                    timer_clear = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef GAME_CTRL_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q;

    // Captured on entry to OVER using the final score, bonus included.
    always_ff @(posedge clk) begin
        if (reset) begin
            hiscore_q <= '0;
        end else if ((state_d == ST_OVER) && (state_q != ST_OVER) && (score_d > hiscore_q)) begin
            hiscore_q <= score_d;
        end
    end

    assign hiscore = hiscore_q;
`else
    // No high-score register in this build.
`endif

    assign state    = state_q;
    assign lives    = lives_q;
    assign goals    = goals_q;
    assign score    = score_q;
    assign game_won = game_won_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with an 8-bit score so saturation is reachable
// within one game; hiscore checks compile in under GAME_CTRL_HISCORE_EN.
module tb_game_ctrl;

    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic [3:0]    dpad_input = '0;
    logic          collision = 1'b0;
    logic          reached_end = 1'b0;
    logic [9:0]    frog_y = 10'd448;
    logic [1:0]    state;
    logic [2:0]    lives;
    logic [2:0]    goals;
    logic [SW-1:0] score;
    logic          game_won;
    logic          death_pulse, win_pulse, lose_pulse;
`ifdef GAME_CTRL_HISCORE_EN
    logic [SW-1:0] hiscore;
`endif

    int total = 0;
    int bad   = 0;

    game_ctrl #(
        .SCORE_W (SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .dpad_input  (dpad_input),
        .collision   (collision),
        .reached_end (reached_end),
        .frog_y      (frog_y),
        .state       (state),
        .lives       (lives),
        .goals       (goals),
        .score       (score),
        .game_won    (game_won),
        .death_pulse (death_pulse),
        .win_pulse   (win_pulse),
        .lose_pulse  (lose_pulse)
`ifdef GAME_CTRL_HISCORE_EN
        ,
        .hiscore     (hiscore)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic press_btn(input logic [3:0] btn);
        dpad_input = btn;
        cyc();
        dpad_input = 4'b0000;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        cyc();
        cyc();
        check_output("rst_state", 32'(state), 0);
        check_output("rst_lives", 32'(lives), 3);
        check_output("rst_goals", 32'(goals), 0);
        check_output("rst_score", 32'(score), 0);
        check_output("rst_won", 32'(game_won), 0);
        check_output("rst_pulses", 32'({death_pulse, win_pulse, lose_pulse}), 0);
`ifdef GAME_CTRL_HISCORE_EN
        check_output("rst_hiscore", 32'(hiscore), 0);
`endif
        reset = 1'b0;
        cyc();
        check_output("idle_hold", 32'(state), 0);

        press_btn(4'b0100);
        check_output("start_state", 32'(state), 1);
        check_output("start_lives", 32'(lives), 3);
        check_output("start_score", 32'(score), 0);
        cyc();

        frog_y = 10'd416; cyc();
        check_output("row13", 32'(score), 1);
        frog_y = 10'd384; cyc();
        check_output("row12", 32'(score), 2);
        frog_y = 10'd416; cyc();
        frog_y = 10'd384; cyc();
        check_output("revisit", 32'(score), 2);

        collision = 1'b1;
        frog_y = 10'd448;
        cyc();
        check_output("hit1_state", 32'(state), 2);
        check_output("hit1_lives", 32'(lives), 2);
        check_output("hit1_death", 32'(death_pulse), 1);
        cyc();
        check_output("hit1_pulse_end", 32'(death_pulse), 0);
        frames(29);
        check_output("hit1_held_state", 32'(state), 2);
        check_output("hit1_held_lives", 32'(lives), 2);
        collision = 1'b0;
        frames(1);
        check_output("hit1_back", 32'(state), 1);
        check_output("hit1_score", 32'(score), 2);

        collision = 1'b1;
        reached_end = 1'b1;
        frog_y = 10'd0;
        cyc();
        collision = 1'b0;
        reached_end = 1'b0;
        frog_y = 10'd448;
        check_output("both_lives", 32'(lives), 1);
        check_output("both_goals", 32'(goals), 0);
        check_output("both_state", 32'(state), 2);
        frames(30);
        check_output("both_back", 32'(state), 1);

        for (int g = 1; g <= 4; g++) begin
            reached_end = 1'b1;
            frog_y = 10'd0;
            cyc();
            reached_end = 1'b0;
            frog_y = 10'd448;
            check_output("cross_goals", 32'(goals), 32'(g));
            check_output("cross_score", 32'(score), 32'(2 + 50 * g));
            check_output("cross_state", 32'(state), 2);
            frames(30);
            check_output("cross_back", 32'(state), 1);
        end

        frog_y = 10'd416; cyc();
        frog_y = 10'd384; cyc();
        frog_y = 10'd352; cyc();
        frog_y = 10'd320; cyc();
        check_output("pre_win_score", 32'(score), 206);

        reached_end = 1'b1;
        frog_y = 10'd0;
        cyc();
        reached_end = 1'b0;
        frog_y = 10'd448;
        check_output("win_state", 32'(state), 3);
        check_output("win_pulse", 32'(win_pulse), 1);
        check_output("win_flag", 32'(game_won), 1);
        check_output("win_goals", 32'(goals), 5);
        check_output("win_score_sat", 32'(score), 255);
`ifdef GAME_CTRL_HISCORE_EN
        check_output("win_hiscore", 32'(hiscore), 255);
`endif
        cyc();
        check_output("win_pulse_end", 32'(win_pulse), 0);

        frames(50);
        press_btn(4'b0001);
        check_output("over_early_press", 32'(state), 3);
        cyc();
        frames(69);
        press_btn(4'b1000);
        check_output("over_119_press", 32'(state), 3);
        cyc();
        frames(1);
        press_btn(4'b0010);
        check_output("over_120_press", 32'(state), 0);
        cyc();

        press_btn(4'b0100);
        check_output("g2_state", 32'(state), 1);
        check_output("g2_lives", 32'(lives), 3);
        check_output("g2_score", 32'(score), 0);
        check_output("g2_goals", 32'(goals), 0);
        check_output("g2_won", 32'(game_won), 0);
`ifdef GAME_CTRL_HISCORE_EN
        check_output("g2_hiscore", 32'(hiscore), 255);
`endif
        cyc();

        collision = 1'b1;
        frame_tick = 1'b1;
        cyc();
        collision = 1'b0;
        frame_tick = 1'b0;
        check_output("g2_hit1_lives", 32'(lives), 2);
        cyc();
        frames(29);
        check_output("entry_tick_ignored", 32'(state), 2);
        frames(1);
        check_output("g2_hit1_back", 32'(state), 1);

        collision = 1'b1;
        cyc();
        collision = 1'b0;
        check_output("g2_hit2_lives", 32'(lives), 1);
        frames(30);
        check_output("g2_hit2_back", 32'(state), 1);

        collision = 1'b1;
        cyc();
        collision = 1'b0;
        check_output("g2_hit3_lives", 32'(lives), 0);
        check_output("g2_hit3_death", 32'(death_pulse), 1);
        frames(29);
        check_output("g2_hit3_wait", 32'(state), 2);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check_output("lose_state", 32'(state), 3);
        check_output("lose_pulse", 32'(lose_pulse), 1);
        check_output("lose_flag", 32'(game_won), 0);
        cyc();
        check_output("lose_pulse_end", 32'(lose_pulse), 0);
`ifdef GAME_CTRL_HISCORE_EN
        check_output("lose_hiscore", 32'(hiscore), 255);
`endif

        frames(120);
        press_btn(4'b0100);
        check_output("restart_idle", 32'(state), 0);
        cyc();
        press_btn(4'b0100);
        check_output("g3_state", 32'(state), 1);
        frog_y = 10'd416;
        cyc();
        check_output("g3_score", 32'(score), 1);

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_output("midrst_state", 32'(state), 0);
        check_output("midrst_score", 32'(score), 0);
        check_output("midrst_lives", 32'(lives), 3);
`ifdef GAME_CTRL_HISCORE_EN
        check_output("midrst_hiscore", 32'(hiscore), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
